// File: rtl/rr_packet_mux.sv
// rr_packet_mux: locks one arbiter-granted source per packet and forwards
// its beats through a one-deep registered output stage.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   s_valid/s_ready     per-source beat handshake (one ready bit at most)
//   s_data/s_last       per-source payload (source i at [i*DATA_W +: DATA_W])
//   req/grant           request vector to / one-hot grant from the arbiter
//   m_valid/m_ready     sink handshake (registered valid)
//   m_data/m_last/m_src sink payload, last flag, source index (registered)
//   busy                a source is locked
//   err                 sticky: bad grant in IDLE or forced release
module rr_packet_mux #(
  parameter int REQ_NUM   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQ_NUM-1:0]          s_valid,
  output logic [REQ_NUM-1:0]          s_ready,
  input  logic [REQ_NUM*DATA_W-1:0]   s_data,
  input  logic [REQ_NUM-1:0]          s_last,
  output logic [REQ_NUM-1:0]          req,
  input  logic [REQ_NUM-1:0]          grant,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_last,
  output logic [$clog2(REQ_NUM)-1:0]  m_src,
  output logic                        busy,
  output logic                        err
);

  localparam int SW = $clog2(REQ_NUM);
  localparam int CW = $clog2(MAX_BEATS) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mv_q, mv_d;
  logic [DATA_W-1:0] md_q, md_d;
  logic              ml_q, ml_d;
  logic [SW-1:0]     ms_q, ms_d;
  logic              err_q, err_d;

  logic [REQ_NUM-1:0] req_c;
  logic [SW-1:0]      g_idx;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               g_onehot;
  logic               out_free;
  logic               end_pkt;

  // grant index and selected-source mux
  always_comb begin
    g_idx     = '0;
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant[i]) g_idx = SW'(i);
      if (sel_q == SW'(i)) begin
        sel_data  = s_data[i*DATA_W +: DATA_W];
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
      end
    end
  end

  assign g_onehot = $onehot(grant);
  assign out_free = ~mv_q | m_ready;
  // a packet ends on s_last or when the beat limit is reached
  assign end_pkt  = sel_last | (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mv_d    = mv_q;
    md_d    = md_q;
    ml_d    = ml_q;
    ms_d    = ms_q;
    err_d   = err_q;
    req_c   = '0;
    s_ready = '0;

    // output register drains regardless of state
    if (mv_q & m_ready) mv_d = 1'b0;

    case (state_q)
      IDLE: begin
        req_c = s_valid;
        if (g_onehot && |(grant & s_valid)) begin
          state_d = LOCK;
          sel_d   = g_idx;
          cnt_d   = '0;
        end else if (|grant && !g_onehot) begin
          err_d = 1'b1;
        end
      end
      LOCK: begin
        s_ready[sel_q] = out_free;
        if (sel_valid & out_free) begin
          mv_d  = 1'b1;
          md_d  = sel_data;
          ms_d  = sel_q;
          ml_d  = end_pkt;
          cnt_d = cnt_q + CW'(1);
          if (end_pkt) begin
            state_d = IDLE;
            if (!sel_last) err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      mv_q    <= 1'b0;
      md_q    <= '0;
      ml_q    <= 1'b0;
      ms_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mv_q    <= mv_d;
      md_q    <= md_d;
      ml_q    <= ml_d;
      ms_q    <= ms_d;
      err_q   <= err_d;
    end
  end

  assign req     = rst ? '0 : req_c;
  assign m_valid = mv_q;
  assign m_data  = md_q;
  assign m_last  = ml_q;
  assign m_src   = ms_q;
  assign busy    = (state_q == LOCK);
  assign err     = err_q;

endmodule
